// File: rtl/ccd_sensor_emulator.sv
// ccd_sensor_emulator
//    Synthetic CCD sensor source. Generates frame-valid / line-valid timing and
//    12-bit test-pattern pixel data like the camera board does, so the capture
//    pipeline can be brought up and checked pixel-by-pixel without a sensor.
//
// Ports
//    iCLK            in   pixel clock
//    iRST            in   synchronous reset, active-high
//    iSTART          in   pulse: begin streaming frames
//    iEND            in   pulse: stop after the current frame
//    iPATTERN[1:0]   in   pattern select, latched at each frame start
//    oFrameValid     out  FVAL
//    oLineValid      out  LVAL
//    oDATA[11:0]     out  pixel data, 0 while LVAL is low
//    oX_Counter[15:0]     column of the pixel on oDATA, 0 while LVAL is low
//    oY_Counter[15:0]     line index within the frame
//    oFrame_Counter[31:0] frames started since reset
//    oBusy           out  high whenever the FSM is not idle
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | not streaming, FVAL=0, waits for the run flag
// FBLANK | inter-frame gap, FVAL=0
// VFRONT | FVAL=1, LVAL=0 before the first line
// LINE   | LVAL=1, one pixel per cycle
// HBLANK | FVAL=1, LVAL=0 between lines
// VBACK  | FVAL=1, LVAL=0 after the last line
module ccd_sensor_emulator #(
   parameter int COLUMN_WIDTH = 1280,
   parameter int ROW_COUNT    = 1024,
   parameter int H_BLANK      = 16,
   parameter int V_FRONT      = 8,
   parameter int V_BACK       = 8,
   parameter int F_BLANK      = 32
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iSTART,
   input  logic        iEND,
   input  logic [1:0]  iPATTERN,
   output logic        oFrameValid,
   output logic        oLineValid,
   output logic [11:0] oDATA,
   output logic [15:0] oX_Counter,
   output logic [15:0] oY_Counter,
   output logic [31:0] oFrame_Counter,
   output logic        oBusy
);

   typedef enum logic [2:0] {IDLE, FBLANK, VFRONT, LINE, HBLANK, VBACK} state_t;

   // Timer reload values: the timer counts down to 0, so a phase of N cycles
   // loads N-1.
   localparam logic [15:0] FB_LAST  = 16'(F_BLANK - 1);
   localparam logic [15:0] VF_LAST  = 16'(V_FRONT - 1);
   localparam logic [15:0] VB_LAST  = 16'(V_BACK - 1);
   localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
   localparam logic [15:0] COL_LAST = 16'(COLUMN_WIDTH - 1);
   localparam logic [15:0] ROW_LAST = 16'(ROW_COUNT - 1);

   state_t      state, stateNext;
   logic        runFlag, runNext;
   logic [15:0] timer, timerNext;
   logic [15:0] xNext, yNext;
   logic [31:0] frameNext;
   logic [1:0]  patLatch, patNext;
   logic [11:0] dataNext, sum;
   logic        fvalNext, timerDone;

   // iEND has priority so a simultaneous start/stop leaves the emulator stopped.
   assign runNext   = iEND ? 1'b0 : (iSTART ? 1'b1 : runFlag);
   assign timerDone = (timer == 16'd0);

   always_comb begin
      stateNext = state;
      timerNext = timer;
      xNext     = oX_Counter;
      yNext     = oY_Counter;
      frameNext = oFrame_Counter;
      patNext   = patLatch;
      unique case (state)
         IDLE: begin
            if (runFlag) begin
               stateNext = FBLANK;
               timerNext = FB_LAST;
            end
         end
         FBLANK: begin
            if (timerDone) begin
               stateNext = VFRONT;
               timerNext = VF_LAST;
               frameNext = oFrame_Counter + 32'd1;
               patNext   = iPATTERN;
               yNext     = 16'd0;
            end else begin
               timerNext = timer - 16'd1;
            end
         end
         VFRONT: begin
            if (timerDone) begin
               stateNext = LINE;
               timerNext = COL_LAST;
               xNext     = 16'd0;
            end else begin
               timerNext = timer - 16'd1;
            end
         end
         LINE: begin
            if (timerDone) begin
               xNext = 16'd0;
               if (oY_Counter < ROW_LAST) begin
                  stateNext = HBLANK;
                  timerNext = HB_LAST;
               end else begin
                  stateNext = VBACK;
                  timerNext = VB_LAST;
               end
            end else begin
               xNext     = oX_Counter + 16'd1;
               timerNext = timer - 16'd1;
            end
         end
         HBLANK: begin
            if (timerDone) begin
               stateNext = LINE;
               timerNext = COL_LAST;
               xNext     = 16'd0;
               yNext     = oY_Counter + 16'd1;
            end else begin
               timerNext = timer - 16'd1;
            end
         end
         VBACK: begin
            if (timerDone) begin
               // A late iSTART (after iEND, before this point) re-arms streaming.
               if (runFlag) begin
                  stateNext = FBLANK;
                  timerNext = FB_LAST;
               end else begin
                  stateNext = IDLE;
                  timerNext = 16'd0;
               end
            end else begin
               timerNext = timer - 16'd1;
            end
         end
         default: begin
            stateNext = IDLE;
            timerNext = 16'd0;
         end
      endcase
   end

   // Outputs are computed from next-state values so every registered output
   // changes on the same edge as the state.
   always_comb begin
      sum      = xNext[11:0] + yNext[11:0] + frameNext[11:0];
      dataNext = 12'd0;
      unique case (patNext)
         2'd0:    dataNext = xNext[11:0];
         2'd1:    dataNext = yNext[11:0];
         2'd2:    dataNext = sum;
         default: dataNext = (xNext[4] ^ yNext[4]) ? 12'hFFF : 12'h000;
      endcase
      if (stateNext != LINE) begin
         dataNext = 12'd0;
      end
      fvalNext = (stateNext == VFRONT) || (stateNext == LINE) ||
                 (stateNext == HBLANK) || (stateNext == VBACK);
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state          <= IDLE;
         runFlag        <= 1'b0;
         timer          <= 16'd0;
         patLatch       <= 2'd0;
         oFrameValid    <= 1'b0;
         oLineValid     <= 1'b0;
         oDATA          <= 12'd0;
         oX_Counter     <= 16'd0;
         oY_Counter     <= 16'd0;
         oFrame_Counter <= 32'd0;
         oBusy          <= 1'b0;
      end else begin
         state          <= stateNext;
         runFlag        <= runNext;
         timer          <= timerNext;
         patLatch       <= patNext;
         oFrameValid    <= fvalNext;
         oLineValid     <= (stateNext == LINE);
         oDATA          <= dataNext;
         oX_Counter     <= xNext;
         oY_Counter     <= yNext;
         oFrame_Counter <= frameNext;
         oBusy          <= (stateNext != IDLE);
      end
   end

endmodule

// File: tb/tb_ccd_sensor_emulator.sv
module tb_ccd_sensor_emulator;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b1;
   logic        iSTART = 1'b0;
   logic        iEND = 1'b0;
   logic [1:0]  iPATTERN = 2'd0;
   logic        oFrameValid, oLineValid, oBusy;
   logic [11:0] oDATA;
   logic [15:0] oX_Counter, oY_Counter;
   logic [31:0] oFrame_Counter;

   ccd_sensor_emulator #(
      .COLUMN_WIDTH(8), .ROW_COUNT(4), .H_BLANK(2),
      .V_FRONT(3), .V_BACK(3), .F_BLANK(4)
   ) dut (
      .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iEND(iEND), .iPATTERN(iPATTERN),
      .oFrameValid(oFrameValid), .oLineValid(oLineValid), .oDATA(oDATA),
      .oX_Counter(oX_Counter), .oY_Counter(oY_Counter),
      .oFrame_Counter(oFrame_Counter), .oBusy(oBusy)
   );

   always #5 iCLK = ~iCLK;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   bit monEn = 1'b0;
   logic [75:0] pixQ[$];
   int fvalLenQ[$];

   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   function automatic logic [11:0] patVal(input int p, input int x, input int y, input int f);
      case (p)
         0: return 12'(x);
         1: return 12'(y);
         2: return 12'(x + y + f);
         default: return ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 12'hFFF : 12'h000;
      endcase
   endfunction

   // Expected frame: 4 lines of 8 pixels, FVAL high 3+32+6+3 = 44 cycles.
   task automatic pushFrame(input int f, input int p);
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 8; x++)
            pixQ.push_back({patVal(p, x, y, f), 16'(x), 16'(y), 32'(f)});
      fvalLenQ.push_back(44);
   endtask

   // Monitor / scoreboard
   int fvalCnt = 0;
   bit prevF = 1'b0;
   logic [75:0] expPix;
   always @(negedge iCLK) begin
      if (monEn) begin
         if (iRST) begin
            fvalCnt = 0;
            prevF = 1'b0;
         end else begin
            if (oLineValid) begin
               check("lval_inside_fval", 96'(oFrameValid), 96'(1));
               if (pixQ.size() == 0) check("pixel_unexpected", 96'(1), 96'(0));
               else begin
                  expPix = pixQ.pop_front();
                  check("pixel", 96'({oDATA, oX_Counter, oY_Counter, oFrame_Counter}), 96'(expPix));
               end
            end else begin
               check("blank_zero", 96'({oDATA, oX_Counter}), 96'(0));
            end
            if (oFrameValid) fvalCnt++;
            else if (prevF) begin
               if (fvalLenQ.size() == 0) check("fval_unexpected", 96'(1), 96'(0));
               else check("fval_len", 96'(fvalCnt), 96'(fvalLenQ.pop_front()));
               fvalCnt = 0;
            end
            prevF = oFrameValid;
         end
      end
   end

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic doReset();
      iRST = 1'b1;
      step();
      step();
      iRST = 1'b0;
   endtask

   task automatic pulseStart();
      iSTART = 1'b1;
      step();
      iSTART = 1'b0;
   endtask

   task automatic pulseEnd();
      iEND = 1'b1;
      step();
      iEND = 1'b0;
   endtask

   task automatic waitRise();
      int n = 0;
      while (!oFrameValid && n < 500) begin step(); n++; end
      check("fval_rise_timeout", 96'(oFrameValid), 96'(1));
   endtask

   task automatic waitFall();
      int n = 0;
      while (oFrameValid && n < 500) begin step(); n++; end
      check("fval_fall_timeout", 96'(oFrameValid), 96'(0));
   endtask

   task automatic waitLine(input int yv);
      int n = 0;
      while (!(oLineValid && oY_Counter == 16'(yv)) && n < 500) begin step(); n++; end
      check("line_timeout", 96'({oLineValid, oY_Counter}), 96'({1'b1, 16'(yv)}));
   endtask

   task automatic waitIdle();
      int n = 0;
      while (oBusy && n < 500) begin step(); n++; end
      check("idle_timeout", 96'(oBusy), 96'(0));
      step();  // let the monitor see the FVAL fall
   endtask

   task automatic checkQuiet(input string name, input int cycles);
      int bad = 0;
      for (int i = 0; i < cycles; i++) begin
         step();
         if (oFrameValid || oBusy) bad++;
      end
      check(name, 96'(bad), 96'(0));
   endtask

   task automatic checkQueuesEmpty(input string name);
      check(name, 96'({pixQ.size(), fvalLenQ.size()}), 96'(0));
   endtask

   int c1, c2;

   initial begin
      // Reset state
      step();
      monEn = 1'b1;
      doReset();
      check("rst_fval", 96'(oFrameValid), 96'(0));
      check("rst_lval", 96'(oLineValid), 96'(0));
      check("rst_data_xy", 96'({oDATA, oX_Counter, oY_Counter}), 96'(0));
      check("rst_frame", 96'(oFrame_Counter), 96'(0));
      check("rst_busy", 96'(oBusy), 96'(0));

      // 1: single frame, pattern 0, FVAL rises on edge 6
      iPATTERN = 2'd0;
      pushFrame(1, 0);
      pulseStart();                       // edge 1
      check("idle_after_edge1", 96'({oBusy, oFrameValid}), 96'(0));
      for (int e = 2; e <= 5; e++) begin
         step();
         check("fblank_fval_low", 96'({oBusy, oFrameValid}), 96'({1'b1, 1'b0}));
      end
      step();                             // edge 6
      check("fval_rise_edge6", 96'(oFrameValid), 96'(1));
      check("frame1_counter", 96'({oFrame_Counter, oY_Counter, oLineValid}), 96'({32'd1, 16'd0, 1'b0}));
      pulseEnd();
      waitIdle();
      check("t1_frame_count", 96'(oFrame_Counter), 96'(1));
      checkQueuesEmpty("t1_all_emitted");

      // 2: pattern 2, two frames, period 48, mid-frame pattern change ignored
      doReset();
      iPATTERN = 2'd2;
      pushFrame(1, 2);
      pushFrame(2, 2);
      pulseStart();
      waitRise();
      c1 = cyc;
      waitFall();
      waitRise();
      c2 = cyc;
      check("frame_period", 96'(c2 - c1), 96'(48));
      check("t2_frame_count", 96'(oFrame_Counter), 96'(2));
      iPATTERN = 2'd3;
      pulseEnd();
      waitIdle();
      check("t2_frame_count_end", 96'(oFrame_Counter), 96'(2));
      checkQueuesEmpty("t2_all_emitted");

      // 3: iEND during line 1 does not truncate, then stays idle
      doReset();
      iPATTERN = 2'd1;
      pushFrame(1, 1);
      pulseStart();
      waitLine(1);
      pulseEnd();
      waitIdle();
      checkQueuesEmpty("t3_all_emitted");
      checkQuiet("t3_idle_100", 100);

      // Re-arm: iSTART after iEND within the frame keeps streaming (pattern 3)
      doReset();
      iPATTERN = 2'd3;
      pushFrame(1, 3);
      pushFrame(2, 3);
      pulseStart();
      waitLine(0);
      pulseEnd();
      step();
      pulseStart();
      waitFall();
      waitRise();
      check("rearm_frame2", 96'(oFrame_Counter), 96'(2));
      pulseEnd();
      waitIdle();
      checkQueuesEmpty("rearm_all_emitted");

      // 4: simultaneous iSTART and iEND from idle
      doReset();
      iSTART = 1'b1;
      iEND = 1'b1;
      step();
      iSTART = 1'b0;
      iEND = 1'b0;
      checkQuiet("t4_no_start", 20);
      check("t4_frame_count", 96'(oFrame_Counter), 96'(0));

      // 5: reset during line 2
      doReset();
      iPATTERN = 2'd0;
      pushFrame(1, 0);
      pulseStart();
      waitLine(2);
      iRST = 1'b1;
      pixQ.delete();
      fvalLenQ.delete();
      step();
      check("t5_fval_lval", 96'({oFrameValid, oLineValid, oBusy}), 96'(0));
      check("t5_data_xy", 96'({oDATA, oX_Counter, oY_Counter}), 96'(0));
      check("t5_frame", 96'(oFrame_Counter), 96'(0));
      step();
      iRST = 1'b0;
      checkQuiet("t5_no_restart", 50);
      check("t5_frame_after", 96'(oFrame_Counter), 96'(0));

      checkQueuesEmpty("final_queues");
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
